// File: rtl/parity_checker.sv
// ---------------------------------------------------------------------------
// parity_checker
//
// Receive-side parity checker for the UART receiver path. It sits after the
// deserializer. On each one-cycle load strobe it registers the data word onto
// dout1 and flags a mismatch between the received and the expected parity bit.
//
// Optional feature macro: PARITY_ERR_COUNT_EN
//   Defined   -> adds the err_clr input, the err_count output and a saturating
//                parity-error counter.
//   Undefined -> those ports and the counter are absent. Everything else
//                behaves the same.
//
// Parameters:
//   DATA_WIDTH   - width of dout / dout1
//   PARITY_MODE  - 0 even, 1 odd, 2 mark (always 1), 3 space (always 0)
//   ERRCNT_WIDTH - width of err_count (only used with PARITY_ERR_COUNT_EN)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   load        in   strobe: dout and rxin are valid this cycle
//   rxin        in   received parity bit
//   dout        in   received data word
//   dout1       out  registered data word (loaded even on parity failure)
//   parityerror out  registered parity-mismatch flag (not sticky)
//   valid       out  one-cycle pulse: dout1/parityerror just updated
//   err_clr     in   synchronous clear of err_count (macro builds only)
//   err_count   out  saturating parity-error count (macro builds only)
// ---------------------------------------------------------------------------
module parity_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_MODE  = 0,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    rxin,
    input  logic [DATA_WIDTH-1:0]   dout,
    output logic [DATA_WIDTH-1:0]   dout1,
    output logic                    parityerror,
    output logic                    valid
`ifdef PARITY_ERR_COUNT_EN
    ,
    input  logic                    err_clr,
    output logic [ERRCNT_WIDTH-1:0] err_count
`endif
);

    // Elaboration-time sanity check on the width parameters.
    if ((DATA_WIDTH < 1) || (ERRCNT_WIDTH < 1)) begin : g_param_check
        $error("parity_checker: DATA_WIDTH and ERRCNT_WIDTH must be >= 1");
    end

    // Expected parity bit for a word under the configured mode.
    function automatic logic calc_exp_parity(input logic [DATA_WIDTH-1:0] data);
        logic result;
        case (PARITY_MODE)
            0:       result = ^data;
            1:       result = ~^data;
            2:       result = 1'b1;
            3:       result = 1'b0;
            default: result = ^data;
        endcase
        return result;
    endfunction

    logic                  w_exp_parity;
    logic                  w_parity_err;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_parityerror;
    logic                  r_valid;

    // Combinational parity compare for the word currently presented.
    always_comb begin
        w_exp_parity = calc_exp_parity(dout);
        w_parity_err = rxin ^ w_exp_parity;
    end

    // Output registers: capture word and mismatch flag on load, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout1       <= '0;
            r_parityerror <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= load;
            if (load) begin
                r_dout1       <= dout;
                r_parityerror <= w_parity_err;
            end else begin
                r_dout1       <= r_dout1;
                r_parityerror <= r_parityerror;
            end
        end
    end

    assign dout1       = r_dout1;
    assign parityerror = r_parityerror;
    assign valid       = r_valid;

`ifdef PARITY_ERR_COUNT_EN
    logic [ERRCNT_WIDTH-1:0] r_err_count;

    // Saturating error counter; a clear on the same edge as an error wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (load && w_parity_err && (r_err_count != {ERRCNT_WIDTH{1'b1}})) begin
            r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_parity_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_checker
//
// Directed bench for parity_checker. Four instances, one per parity mode,
// share the same stimulus. Expected words and flags are computed from the
// stimulus and pushed onto a scoreboard queue. They are popped and compared
// one clock after each load. With PARITY_ERR_COUNT_EN defined, an extra
// instance with a 2-bit counter is used to check saturation and clear priority.
// ---------------------------------------------------------------------------
module tb_parity_checker;

    typedef struct {
        logic [7:0] d;
        logic [3:0] pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       rxin;
    logic [7:0] dout;
    logic       err_clr;

    logic [7:0] w_dout1 [4];
    logic [3:0] w_perr;
    logic [3:0] w_valid;

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] w_cnt_unused [4];
    logic [7:0] w_c_dout1;
    logic       w_c_perr;
    logic       w_c_valid;
    logic [1:0] w_c_count;
`endif

    exp_t       sb[$];
    logic [7:0] held_d;
    logic [3:0] held_pe;
    int         cnt_model;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        parity_checker #(
            .DATA_WIDTH  (8),
            .PARITY_MODE (m),
            .ERRCNT_WIDTH(8)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .rxin       (rxin),
            .dout       (dout),
            .dout1      (w_dout1[m]),
            .parityerror(w_perr[m]),
            .valid      (w_valid[m])
`ifdef PARITY_ERR_COUNT_EN
            ,
            .err_clr    (err_clr),
            .err_count  (w_cnt_unused[m])
`endif
        );
    end

`ifdef PARITY_ERR_COUNT_EN
    parity_checker #(
        .DATA_WIDTH  (8),
        .PARITY_MODE (0),
        .ERRCNT_WIDTH(2)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .rxin       (rxin),
        .dout       (dout),
        .dout1      (w_c_dout1),
        .parityerror(w_c_perr),
        .valid      (w_c_valid),
        .err_clr    (err_clr),
        .err_count  (w_c_count)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the expected parity flag for each mode.
    function automatic logic [3:0] model_pe(input logic [7:0] d, input logic rx);
        logic [3:0] r;
        int ones;
        ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(d[b]);
        r[0] = rx != ((ones % 2) == 1);   // even: parity bit makes total even
        r[1] = rx != ((ones % 2) == 0);   // odd
        r[2] = rx != 1'b1;                // mark
        r[3] = rx != 1'b0;                // space
        return r;
    endfunction

    task automatic check_all(input string tag, input logic exp_valid);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s.dout1[m%0d]", tag, m), {24'd0, w_dout1[m]}, {24'd0, held_d});
            chk($sformatf("%s.perr[m%0d]", tag, m), {31'd0, w_perr[m]}, {31'd0, held_pe[m]});
            chk($sformatf("%s.valid[m%0d]", tag, m), {31'd0, w_valid[m]}, {31'd0, exp_valid});
        end
`ifdef PARITY_ERR_COUNT_EN
        chk($sformatf("%s.err_count", tag), {30'd0, w_c_count}, cnt_model);
`endif
    endtask

    // One clocked step: drive inputs, push expectation, check after the edge.
    task automatic step(input string tag, input logic ld, input logic rx,
                        input logic [7:0] d, input logic clr);
        exp_t e;
        load    = ld;
        rxin    = rx;
        dout    = d;
        err_clr = clr;
        if (ld) begin
            e.d  = d;
            e.pe = model_pe(d, rx);
            sb.push_back(e);
        end
        if (clr) cnt_model = 0;
        else if (ld && model_pe(d, rx)[0] && cnt_model < 3) cnt_model++;
        if (!ld) begin
            // Glitch between edges must not be captured.
            #2 rxin = ~rxin;
            dout = ~dout;
        end
        @(posedge clk);
        #1;
        if (ld) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e       = sb.pop_front();
                held_d  = e.d;
                held_pe = e.pe;
            end
        end
        check_all(tag, ld);
    endtask

    initial begin
        held_d    = 8'h00;
        held_pe   = 4'h0;
        cnt_model = 0;
        reset     = 1'b0;
        load      = 1'b1;
        rxin      = 1'b1;
        dout      = 8'h09;
        err_clr   = 1'b0;

        // Reset held with load active: outputs stay at reset values.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 1'b0);

        load  = 1'b0;
        reset = 1'b1;
        step("post_reset", 1'b0, 1'b0, 8'h00, 1'b0);

        step("even_mismatch", 1'b1, 1'b1, 8'h09, 1'b0);
        chk("even_mismatch.perr_lit", {31'd0, w_perr[0]}, 32'd1);
        step("even_match", 1'b1, 1'b0, 8'h09, 1'b0);
        chk("even_match.dout1_lit", {24'd0, w_dout1[0]}, 32'h09);
        step("hold_a", 1'b0, 1'b1, 8'hFF, 1'b0);
        step("hold_b", 1'b0, 1'b0, 8'hFF, 1'b0);
        step("odd_ok", 1'b1, 1'b0, 8'h01, 1'b0);
        chk("odd_ok.perr_lit", {31'd0, w_perr[1]}, 32'd0);
        step("mark_rx0", 1'b1, 1'b0, 8'h5A, 1'b0);
        chk("mark_rx0.perr_lit", {31'd0, w_perr[2]}, 32'd1);

        // Back-to-back loads with load held high.
        step("b2b_0", 1'b1, 1'b0, 8'h00, 1'b0);
        step("b2b_1", 1'b1, 1'b1, 8'hFF, 1'b0);
        step("b2b_2", 1'b1, 1'b1, 8'hA5, 1'b0);
        step("b2b_3", 1'b1, 1'b0, 8'h80, 1'b0);
        step("b2b_4", 1'b1, 1'b1, 8'h7F, 1'b0);
        step("idle", 1'b0, 1'b0, 8'h3C, 1'b0);

        // Asynchronous reset takes effect without a clock edge.
        step("pre_async", 1'b1, 1'b1, 8'hC3, 1'b0);
        reset = 1'b0;
        #2;
        held_d    = 8'h00;
        held_pe   = 4'h0;
        cnt_model = 0;
        check_all("async_reset", 1'b0);
        load = 1'b1;
        dout = 8'hE7;
        rxin = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_wins", 1'b0);
        reset = 1'b1;
        step("after_async", 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef PARITY_ERR_COUNT_EN
        // Five erroring even-mode loads saturate a 2-bit counter at 3.
        for (int k = 0; k < 5; k++) begin
            step($sformatf("sat_%0d", k), 1'b1, 1'b0, 8'h01, 1'b0);
        end
        chk("sat.lit", {30'd0, w_c_count}, 32'd3);
        step("clr_vs_err", 1'b1, 1'b0, 8'h01, 1'b1);
        chk("clr_vs_err.lit", {30'd0, w_c_count}, 32'd0);
        step("count_again", 1'b1, 1'b1, 8'h02, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
